alu_pipe: RTL and testbench
===========================

ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter WIDTH, default 32, datapath width; SHALL be a power of two, 8..64.
REQ-002 Derived localparam SHW = $clog2(WIDTH), shift-amount width.
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 in_valid  in  1  operand/opcode present.
REQ-006 in_ready  out  1  block accepts an operation this cycle.
REQ-007 op  in  4  op[2:0] = ALU code; op[3] = 1 selects multiply.
REQ-008 ctrl  in  1  add: 0, sub: 1; right shift: 0 logical, 1 arithmetic.
REQ-009 src_a, src_b  in  WIDTH  operands.
REQ-010 out_valid  out  1  result and flags valid.
REQ-011 out_ready  in  1  consumer takes result.
REQ-012 result  out  WIDTH  primary result; mul_hi  out  WIDTH  upper product half.
REQ-013 carry, overflow, sign, equal, greater, less  out  1 each  registered flags.

Function
REQ-014 ALU codes SHALL be: 000 add/sub; 001 shift left; 010 signed set-less-than; 011 unsigned set-less-than; 100 xor; 101 shift right; 110 or; 111 and.
REQ-015 Shift amount SHALL be src_b[SHW-1:0]; arithmetic replication is applied only for code 101 with ctrl=1.
REQ-016 Codes 010/011 SHALL give result = 1 when src_a < src_b, else 0, zero-extended to WIDTH.
REQ-017 Add/sub: carry = carry-out of the WIDTH-bit sum, or the borrow-free carry of a + ~b + 1 on sub; overflow = signed overflow; sign = result MSB.
REQ-018 equal/greater/less SHALL be valid for 010/011 only; carry/overflow/sign for 000 only; all other flags SHALL be 0, never high-Z.
REQ-019 mul_hi SHALL be 0 for every operation except multiply.
REQ-020 Transfers: input accepted when in_valid & in_ready; output consumed when out_valid & out_ready.
REQ-021 FSM states: IDLE, MUL, DONE.
REQ-022 IDLE: accepted ALU op -> DONE, with result/flags registered (latency 1 cycle); accepted multiply -> MUL.
REQ-023 MUL: unsigned shift-and-add, one multiplier bit per cycle, bit counter 0..WIDTH-1; when the counter reaches WIDTH-1 -> DONE with {mul_hi, result} = src_a * src_b (latency WIDTH+1 cycles from acceptance); multiply ignores ctrl.
REQ-024 DONE: out_valid = 1; result/flags SHALL hold stable until out_ready.
REQ-025 in_ready = 1 in IDLE, or in DONE when out_ready = 1; 0 in MUL.
REQ-026 DONE with out_ready = 1 and in_valid = 1 SHALL consume the output and accept the new op in the same cycle (back-to-back, one result per cycle for ALU ops).
REQ-027 DONE with out_ready = 1 and in_valid = 0 -> IDLE; out_valid drops the next cycle.
REQ-028 Operands SHALL be captured at acceptance; input changes afterwards SHALL not affect the result in flight.
REQ-029 Multiply counter SHALL not wrap; exit at WIDTH-1 is the only way out of MUL except reset.

Reset
REQ-030 rst = 1 SHALL force IDLE and clear the counter, out_valid, result, mul_hi and all flags to 0 on the next clock edge; in_ready = 1 after reset.
REQ-031 Reset during MUL or DONE SHALL abort and drop the operation without producing out_valid.

Configuration
REQ-032 Macro ALU_PIPE_MUL_EN: when defined, multiply is implemented as above.
REQ-033 When ALU_PIPE_MUL_EN is not defined, no MUL state or multiplier logic is built. An op[3] = 1 op SHALL complete in 1 cycle with result = 0, mul_hi = 0 and all flags 0.

Verification
REQ-034 WIDTH=32: add 0xFFFFFFFF + 0x00000001, ctrl=0 -> result 0x00000000, carry=1, overflow=0, sign=0, out_valid 1 cycle after accept.
REQ-035 Sub 0x80000000 - 0x00000001, ctrl=1 -> result 0x7FFFFFFF, overflow=1, sign=0; then signed slt 0xFFFFFFFF vs 0x00000001 -> result 1, less=1; unsigned slt on the same operands -> result 0, greater=1.
REQ-036 Shift right, ctrl=1, 0x80000000 by src_b = 0x00000024 (amount 4) -> result 0xF8000000; ctrl=0 -> result 0x08000000.
REQ-037 Multiply (MUL_EN defined) 0xFFFFFFFF * 0x00000002 -> mul_hi 0x00000001, result 0xFFFFFFFE, out_valid exactly 33 cycles after accept, in_ready=0 throughout MUL.
REQ-038 Backpressure: hold out_ready=0 for 5 cycles in DONE with in_valid=1 -> result stable, in_ready=0; then out_ready=1 -> output consumed and new op accepted in the same cycle; 4 back-to-back xors yield 4 results on 4 consecutive cycles.
REQ-039 Assert rst at cycle 10 of a multiply -> next cycle IDLE, out_valid=0, all outputs 0; a following add completes normally.

Source files
------------

// File: rtl/alu_pipe.sv
// alu_pipe: single-issue ALU with registered result and flags, plus an
// optional iterative shift-and-add multiplier.
//
// Build option: define ALU_PIPE_MUL_EN to include the multiplier (MUL state,
// bit counter, product register). Without it, op[3]=1 completes in one cycle
// with result, mul_hi and all flags forced to zero.
//
// Handshake: an operation is accepted on a rising edge where
// in_valid && in_ready; a result is consumed on a rising edge where
// out_valid && out_ready. The producer holds op/ctrl/src_* stable while
// in_valid is high and in_ready is low. result/mul_hi/flags stay stable
// while out_valid is high and out_ready is low.
//
// dbg_state exposes the FSM state: 0 = IDLE, 1 = MUL, 2 = DONE.
module alu_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic             ctrl,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] mul_hi,
  output logic             carry,
  output logic             overflow,
  output logic             sign,
  output logic             equal,
  output logic             greater,
  output logic             less,
  output logic [1:0]       dbg_state
);

  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
`ifdef ALU_PIPE_MUL_EN
    MUL  = 2'd1,
`endif
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   accept;

  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum_ext;
  logic [SHW-1:0]   shamt;
  logic             alu_c, alu_v, alu_s, alu_e, alu_g, alu_l;

  assign accept    = in_valid & in_ready;
  assign dbg_state = state_q;

  // Combinational ALU evaluated on the live inputs; its outputs are only
  // captured on the accepting edge.
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_s   = 1'b0;
    alu_e   = 1'b0;
    alu_g   = 1'b0;
    alu_l   = 1'b0;
    b_eff   = ctrl ? ~src_b : src_b;
    sum_ext = {1'b0, src_a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, ctrl};
    shamt   = src_b[SHW-1:0];
    case (op[2:0])
      3'b000: begin
        alu_res = sum_ext[WIDTH-1:0];
        alu_c   = sum_ext[WIDTH];
        alu_v   = (src_a[WIDTH-1] == b_eff[WIDTH-1]) &&
                  (sum_ext[WIDTH-1] != src_a[WIDTH-1]);
        alu_s   = sum_ext[WIDTH-1];
      end
      3'b001: alu_res = src_a << shamt;
      3'b010: begin
        alu_l   = $signed(src_a) < $signed(src_b);
        alu_g   = $signed(src_a) > $signed(src_b);
        alu_e   = src_a == src_b;
        alu_res = {{(WIDTH-1){1'b0}}, alu_l};
      end
      3'b011: begin
        alu_l   = src_a < src_b;
        alu_g   = src_a > src_b;
        alu_e   = src_a == src_b;
        alu_res = {{(WIDTH-1){1'b0}}, alu_l};
      end
      3'b100: alu_res = src_a ^ src_b;
      3'b101: alu_res = ctrl ? $unsigned($signed(src_a) >>> shamt) : (src_a >> shamt);
      3'b110: alu_res = src_a | src_b;
      default: alu_res = src_a & src_b;
    endcase
  end

`ifdef ALU_PIPE_MUL_EN
  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  logic [SHW-1:0]     cnt_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [2*WIDTH-1:0] prod_q, prod_next;
  logic [WIDTH:0]     partial;

  // One shift-and-add step: the multiplier sits in the low half of prod_q
  // and is consumed LSB first while the partial sum shifts in from the top.
  always_comb begin
    partial   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    prod_next = {partial, prod_q[WIDTH-1:1]};
  end

  // Multiplier registers: load at acceptance, step once per MUL cycle;
  // the counter saturates at its last value instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      mcand_q <= '0;
      prod_q  <= '0;
    end else if (accept && op[3]) begin
      cnt_q   <= '0;
      mcand_q <= src_a;
      prod_q  <= {{WIDTH{1'b0}}, src_b};
    end else if (state_q == MUL) begin
      prod_q <= prod_next;
      if (cnt_q != CNT_LAST) cnt_q <= cnt_q + SHW'(1);
    end
  end
`endif

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
`ifdef ALU_PIPE_MUL_EN
          state_d = op[3] ? MUL : DONE;
`else
          state_d = DONE;
`endif
        end
      end
`ifdef ALU_PIPE_MUL_EN
      MUL: begin
        if (cnt_q == CNT_LAST) state_d = DONE;
      end
`endif
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) begin
          if (in_valid) begin
`ifdef ALU_PIPE_MUL_EN
            state_d = op[3] ? MUL : DONE;
`else
            state_d = DONE;
`endif
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output registers: ALU results land on the accepting edge, products on
  // the final multiply step; everything holds otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      result   <= '0;
      mul_hi   <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      sign     <= 1'b0;
      equal    <= 1'b0;
      greater  <= 1'b0;
      less     <= 1'b0;
    end else if (accept) begin
      mul_hi   <= '0;
      result   <= op[3] ? '0 : alu_res;
      carry    <= ~op[3] & alu_c;
      overflow <= ~op[3] & alu_v;
      sign     <= ~op[3] & alu_s;
      equal    <= ~op[3] & alu_e;
      greater  <= ~op[3] & alu_g;
      less     <= ~op[3] & alu_l;
    end
`ifdef ALU_PIPE_MUL_EN
    else if (state_q == MUL && cnt_q == CNT_LAST) begin
      result <= prod_next[WIDTH-1:0];
      mul_hi <= prod_next[2*WIDTH-1:WIDTH];
    end
`endif
  end

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: self-checking bench for alu_pipe (WIDTH=32).
// Multiply scenarios follow ALU_PIPE_MUL_EN, matching the RTL build.
module tb_alu_pipe;

  localparam int W  = 32;
  localparam int PK = 2*W + 6;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   op = '0;
  logic         ctrl = 1'b0;
  logic [W-1:0] src_a = '0;
  logic [W-1:0] src_b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result, mul_hi;
  logic         carry, overflow, sign, equal, greater, less;
  logic [1:0]   dbg_state;

  logic [PK-1:0] obs;
  logic [PK-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  assign obs = {mul_hi, result, carry, overflow, sign, equal, greater, less};

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  alu_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .ctrl(ctrl), .src_a(src_a), .src_b(src_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .mul_hi(mul_hi),
    .carry(carry), .overflow(overflow), .sign(sign),
    .equal(equal), .greater(greater), .less(less),
    .dbg_state(dbg_state)
  );

  // Reference model: arithmetic on wide integers, packed as
  // {mul_hi, result, carry, overflow, sign, equal, greater, less}.
  function automatic logic [PK-1:0] model(input logic [3:0] o, input logic c,
                                          input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] res, hi;
    logic fc, fv, fs, fe, fg, fl;
    longint sa, sb, ssum, lim_hi, lim_lo;
    longint unsigned ua, ub, prod;
    int amt;
    res = '0; hi = '0;
    fc = 0; fv = 0; fs = 0; fe = 0; fg = 0; fl = 0;
    ua = longint'(a); ub = longint'(b);
    sa = longint'($signed(a)); sb = longint'($signed(b));
    amt = int'(ub % W);
    lim_hi = (longint'(1) <<< (W-1)) - 1;
    lim_lo = -(longint'(1) <<< (W-1));
    if (o[3]) begin
`ifdef ALU_PIPE_MUL_EN
      prod = ua * ub;
      res = prod[W-1:0];
      hi  = prod[2*W-1:W];
`else
      prod = 0;
`endif
    end else begin
      case (o[2:0])
        3'd0: begin
          if (c) begin
            ssum = sa - sb;
            res  = W'(ua - ub);
            fc   = (ua >= ub);
          end else begin
            ssum = sa + sb;
            res  = W'(ua + ub);
            fc   = ((ua + ub) >> W) != 0;
          end
          fv = (ssum > lim_hi) || (ssum < lim_lo);
          fs = res[W-1];
        end
        3'd1: res = W'(ua << amt);
        3'd2: begin fe = sa == sb; fg = sa > sb; fl = sa < sb; res = W'(fl); end
        3'd3: begin fe = ua == ub; fg = ua > ub; fl = ua < ub; res = W'(fl); end
        3'd4: res = a ^ b;
        3'd5: res = c ? W'(sa >>> amt) : W'(ua >> amt);
        3'd6: res = a | b;
        default: res = a & b;
      endcase
    end
    return {hi, res, fc, fv, fs, fe, fg, fl};
  endfunction

  function automatic logic [W-1:0] rand_operand();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return W'(1);
      2: return '1;
      3: return {1'b1, {(W-1){1'b0}}};
      4: return {1'b0, {(W-1){1'b1}}};
      default: return W'($urandom);
    endcase
  endfunction

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    op = '0; ctrl = 1'b0; src_a = '0; src_b = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  // Driver: offer one op, wait for acceptance, scramble inputs, wait for the
  // result, capture it and consume it. lat counts edges from acceptance
  // (1 = result visible right after the accepting edge).
  task automatic run_one(input logic [3:0] o, input logic c,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [PK-1:0] got, output int lat, output int busy_ready);
    int t;
    got = '0; lat = -1; busy_ready = 0;
    @(negedge clk);
    op = o; ctrl = c; src_a = a; src_b = b; in_valid = 1'b1; out_ready = 1'b0;
    exp_q.push_back(model(o, c, a, b));
    #1;
    t = 0;
    while (!in_ready && t < 100) begin @(negedge clk); t++; end
    if (!in_ready) begin in_valid = 1'b0; return; end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    op = 4'($urandom); ctrl = 1'($urandom); src_a = W'($urandom); src_b = W'($urandom);
    lat = 1;
    while (!out_valid && lat < 200) begin
      if (in_ready) busy_ready++;
      @(negedge clk);
      lat++;
    end
    got = obs;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (obs !== '0) begin errors++; $display("FAIL reset_outputs: got %h expected 0", obs); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++;
    if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
  endtask

  task automatic test_directed();
    logic [3:0] o; logic c; logic [W-1:0] a, b;
    logic [PK-1:0] want, got, exp;
    int lat, busy;
    for (int i = 0; i < 6; i++) begin
      case (i)
        0: begin o = 4'h0; c = 1'b0; a = 32'hFFFF_FFFF; b = 32'h1; want = {32'h0, 32'h0, 6'b100000}; end
        1: begin o = 4'h0; c = 1'b1; a = 32'h8000_0000; b = 32'h1; want = {32'h0, 32'h7FFF_FFFF, 6'b110000}; end
        2: begin o = 4'h2; c = 1'b0; a = 32'hFFFF_FFFF; b = 32'h1; want = {32'h0, 32'h1, 6'b000001}; end
        3: begin o = 4'h3; c = 1'b0; a = 32'hFFFF_FFFF; b = 32'h1; want = {32'h0, 32'h0, 6'b000010}; end
        4: begin o = 4'h5; c = 1'b1; a = 32'h8000_0000; b = 32'h24; want = {32'h0, 32'hF800_0000, 6'b0}; end
        default: begin o = 4'h5; c = 1'b0; a = 32'h8000_0000; b = 32'h24; want = {32'h0, 32'h0800_0000, 6'b0}; end
      endcase
      run_one(o, c, a, b, got, lat, busy);
      exp = exp_q.pop_front();
      checks++;
      if (got !== want) begin errors++; $display("FAIL directed_%0d: got %h expected %h", i, got, want); end
      checks++;
      if (got !== exp) begin errors++; $display("FAIL directed_model_%0d: got %h expected %h", i, got, exp); end
      checks++;
      if (lat != 1) begin errors++; $display("FAIL directed_latency_%0d: got %0d expected 1", i, lat); end
    end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL drop_after_consume: got %b expected 0", out_valid); end
  endtask

  task automatic test_random_alu();
    logic [3:0] o; logic c; logic [W-1:0] a, b;
    logic [PK-1:0] got, exp;
    int lat, busy;
    for (int i = 0; i < 40; i++) begin
      o = {1'b0, 3'($urandom)}; c = 1'($urandom);
      a = rand_operand(); b = rand_operand();
      run_one(o, c, a, b, got, lat, busy);
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp || lat != 1) begin
        errors++;
        $display("FAIL random_alu op=%h ctrl=%b a=%h b=%h: got %h lat %0d expected %h lat 1",
                 o, c, a, b, got, lat, exp);
      end
    end
  endtask

  task automatic test_mul();
    logic [W-1:0] a, b;
    logic [PK-1:0] got, exp;
    int lat, busy;
`ifdef ALU_PIPE_MUL_EN
    run_one(4'h8, 1'b0, 32'hFFFF_FFFF, 32'h2, got, lat, busy);
    exp = exp_q.pop_front();
    checks++;
    if (got !== {32'h1, 32'hFFFF_FFFE, 6'b0}) begin
      errors++; $display("FAIL mul_directed: got %h expected %h", got, {32'h1, 32'hFFFF_FFFE, 6'b0});
    end
    checks++;
    if (lat != W + 1) begin errors++; $display("FAIL mul_latency: got %0d expected %0d", lat, W + 1); end
    checks++;
    if (busy != 0) begin errors++; $display("FAIL mul_in_ready: got %0d ready cycles expected 0", busy); end
    for (int i = 0; i < 6; i++) begin
      a = rand_operand(); b = rand_operand();
      run_one({1'b1, 3'($urandom)}, 1'($urandom), a, b, got, lat, busy);
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp || lat != W + 1 || busy != 0) begin
        errors++;
        $display("FAIL mul_random a=%h b=%h: got %h lat %0d busy %0d expected %h lat %0d busy 0",
                 a, b, got, lat, busy, exp, W + 1);
      end
    end
`else
    for (int i = 0; i < 6; i++) begin
      a = rand_operand(); b = rand_operand();
      run_one({1'b1, 3'($urandom)}, 1'($urandom), a, b, got, lat, busy);
      exp = exp_q.pop_front();
      checks++;
      if (got !== '0 || got !== exp || lat != 1) begin
        errors++;
        $display("FAIL mul_disabled a=%h b=%h: got %h lat %0d expected 0 lat 1", a, b, got, lat);
      end
    end
`endif
  endtask

  task automatic test_backpressure();
    logic [W-1:0] a0, b0, a1, b1;
    logic [PK-1:0] exp0, exp1;
    a0 = W'($urandom); b0 = W'($urandom); a1 = W'($urandom); b1 = W'($urandom);
    exp0 = model(4'h4, 1'b0, a0, b0);
    exp1 = model(4'h4, 1'b0, a1, b1);
    @(negedge clk);
    op = 4'h4; ctrl = 1'b0; src_a = a0; src_b = b0; in_valid = 1'b1; out_ready = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_first_ready: got %b expected 1", in_ready); end
    @(posedge clk);
    @(negedge clk);
    src_a = a1; src_b = b1;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || obs !== exp0) begin
        errors++;
        $display("FAIL bp_hold_%0d: got valid %b ready %b out %h expected valid 1 ready 0 out %h",
                 k, out_valid, in_ready, obs, exp0);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b expected 1", in_ready); end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || obs !== exp1) begin
      errors++; $display("FAIL bp_second: got valid %b out %h expected valid 1 out %h", out_valid, obs, exp1);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_idle: got %b expected 0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a[4], b[4];
    logic [PK-1:0] exp;
    for (int i = 0; i < 4; i++) begin a[i] = W'($urandom); b[i] = W'($urandom); end
    @(negedge clk);
    op = 4'h4; ctrl = 1'b0; src_a = a[0]; src_b = b[0]; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_%0d: got %b expected 1", i, in_ready); end
      exp_q.push_back(model(4'h4, 1'b0, a[i], b[i]));
      @(posedge clk);
      @(negedge clk);
      if (i < 3) begin src_a = a[i+1]; src_b = b[i+1]; end
      else in_valid = 1'b0;
      exp = exp_q.pop_front();
      checks++;
      if (out_valid !== 1'b1 || obs !== exp) begin
        errors++; $display("FAIL b2b_result_%0d: got valid %b out %h expected valid 1 out %h", i, out_valid, obs, exp);
      end
      #1;
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle: got %b expected 0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_abort();
    logic [PK-1:0] got, exp;
    int lat, busy, seen;
    // Abort a finished-but-unconsumed ALU result.
    @(negedge clk);
    op = 4'h0; ctrl = 1'b0; src_a = W'($urandom); src_b = W'($urandom); in_valid = 1'b1; out_ready = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL abort_done_accept: got %b expected 1", in_ready); end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL abort_done_valid: got %b expected 1", out_valid); end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (obs !== '0 || out_valid !== 1'b0 || in_ready !== 1'b1 || dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL abort_done_clear: got out %h valid %b ready %b state %0d expected 0 0 1 0",
               obs, out_valid, in_ready, dbg_state);
    end
`ifdef ALU_PIPE_MUL_EN
    // Abort a multiply at its tenth cycle.
    @(negedge clk);
    op = 4'h8; src_a = W'($urandom); src_b = W'($urandom); in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    seen = 0;
    for (int k = 1; k < 10; k++) begin
      if (in_ready || out_valid) seen++;
      @(negedge clk);
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL abort_mul_busy: got %0d cycles ready/valid expected 0", seen); end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (obs !== '0 || out_valid !== 1'b0 || in_ready !== 1'b1 || dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL abort_mul_clear: got out %h valid %b ready %b state %0d expected 0 0 1 0",
               obs, out_valid, in_ready, dbg_state);
    end
`endif
    seen = 0;
    for (int k = 0; k < W + 5; k++) begin
      if (out_valid) seen++;
      @(negedge clk);
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL abort_no_valid: got %0d valid cycles expected 0", seen); end
    run_one(4'h0, 1'b0, 32'h1234_5678, 32'h1111_1111, got, lat, busy);
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp || lat != 1) begin
      errors++; $display("FAIL abort_followup: got %h lat %0d expected %h lat 1", got, lat, exp);
    end
  endtask

  // Test sequence and final report.
  initial begin
    do_reset();
    @(negedge clk);
    test_reset();
    test_directed();
    test_random_alu();
    test_mul();
    test_backpressure();
    test_back_to_back();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
